tag_stream_parser: RTL and testbench
====================================

// Module: tag_stream_parser
// PURPOSE
//  Streaming XML/HTML tag tokenizer: consumes one char per handshake from the raw document stream
//  and emits typed events. Event types are START, END and ATTR; SELF_CLOSE is emitted only with SELF_CLOSING_EN.
//  Generalises the single-tag parser: runs continuously, captures full names and values, and has backpressure.
//  Sits between the document byte source and the DOM/layout builder.
// PARAMETERS
//  CHAR_W    8   bits per character
//  NAME_LEN  8   max stored chars of tag name / attribute key
//  VAL_LEN   16  max stored chars of attribute value
// PORTS
//  clock          in   1                 single clock, all logic posedge
//  reset          in   1                 synchronous, active-high
//  in_char        in   CHAR_W            input character
//  in_valid       in   1                 in_char valid
//  in_ready       out  1                 = !evt_valid | evt_ready (combinational)
//  evt_valid      out  1                 event register holds an event
//  evt_ready      in   1                 consumer accepts event
//  evt_type       out  3                 START=0 END=1 ATTR=2 SELF_CLOSE=3 ERROR=7
//  evt_name       out  NAME_LEN*CHAR_W   tag name or attr key; char i at [i*CHAR_W +: CHAR_W]; unused bytes 0
//  evt_name_len   out  $clog2(NAME_LEN+1) stored name chars
//  evt_value      out  VAL_LEN*CHAR_W    attr value (ATTR only, else 0), same packing
//  evt_value_len  out  $clog2(VAL_LEN+1) stored value chars
//  evt_trunc      out  1                 name or value exceeded its buffer; extra chars dropped
// BEHAVIOUR
//  - Char accepted when in_valid & in_ready. Event reg loads on the cycle of the accepting char: 1-cycle latency.
//  - evt_* hold steady while evt_valid & !evt_ready. evt_valid clears on evt_ready unless a new event loads the same cycle.
//  - Reset: FSM=CONTENT; buffers, lengths, evt_* all 0; in_ready=1.
//  - Whitespace (WS) = space, tab, CR, LF.
//  - FSM:
//    - CONTENT: '<' -> OPEN; all else discarded.
//    - OPEN: '/' -> set is_end, stay OPEN; a repeated '/' -> ERROR.
//      - Name char (not WS, '>', '<', '=', '"') -> append, -> NAME.
//      - '>' or WS with empty name -> ERROR.
//    - NAME: name char -> append.
//      - WS -> emit START (or END if is_end), -> ATTR_WS.
//      - '>' -> emit START/END, -> CONTENT.
//      - '/' -> emit START, -> SLASH.
//    - ATTR_WS: WS skipped; '>' -> CONTENT; '/' -> SLASH; key char -> KEY.
//    - KEY: key char appends; '=' -> EQ; '>' / WS -> emit ATTR with empty value.
//    - EQ: '"' -> VAL; else ERROR.
//    - VAL: any char except '"' appends (may include '>' and '<'); '"' -> emit ATTR, -> ATTR_WS.
//    - SLASH: '>' -> see CONFIGURATION, -> CONTENT; else ERROR.
//  - Attributes on an END tag are parsed and emitted normally.
//  - ERROR: emit ERROR event (name = partial buffer), -> CONTENT; that char is not reinterpreted.
//    - '<' anywhere except VAL/CONTENT is an ERROR.
//  - Buffers clear after each event they feed. Tag name is kept until the tag's closing '>' for SELF_CLOSE.
//  - Append at full buffer: char dropped, sticky trunc flag set; flag cleared with the buffer.
//  - Reset mid-tag or while evt_valid: event dropped, FSM -> CONTENT.
// CONFIGURATION
//  SELF_CLOSING_EN defined: "/>" emits SELF_CLOSE (evt_name = tag name) after the START already sent.
//  SELF_CLOSING_EN undefined: SLASH absent; '/' in NAME/ATTR_WS is treated as WS (legacy); no type 3 ever.
// STRUCTURE
//  xml_pkg: event type localparams, state enum, char constants ("<" ">" "/" "=" '"' WS set).
//  Sub-module char_accum #(LEN,CHAR_W): clear/append, packed buffer, len, sticky trunc.
//    Instanced twice: name/key and value.
// TESTING
//  "<div>" evt_ready=1 -> START "div" len3, exactly one event.
//  "</p>" -> END "p".
//  "<a href=\"x>y\">" -> START "a", then ATTR key "href" value "x>y" len3.
//  "<body>", evt_ready=0 for 5 cycles -> in_ready low; event held stable; no char lost.
//  NAME_LEN=4, "<abcdefg>" -> START "abcd", len4, trunc=1.
//  "<img/>" with SELF_CLOSING_EN -> START "img" then SELF_CLOSE "img".
//    Without it -> START only.
//  "<=x>" -> ERROR.
//  Reset asserted mid "<di" then "<p>" -> START "p" only.

Source files
------------

// File: rtl/xml_pkg.sv
// Shared event codes, parser states and character classes for tag_stream_parser.
package xml_pkg;

  localparam logic [2:0] EVT_START      = 3'd0;
  localparam logic [2:0] EVT_END        = 3'd1;
  localparam logic [2:0] EVT_ATTR       = 3'd2;
  localparam logic [2:0] EVT_SELF_CLOSE = 3'd3;
  localparam logic [2:0] EVT_ERROR      = 3'd7;

  localparam logic [7:0] CH_LT    = 8'h3C;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_QUOTE = 8'h22;

  typedef enum logic [2:0] {
    S_CONTENT,
    S_OPEN,
    S_NAME,
    S_ATTR_WS,
    S_KEY,
    S_EQ,
    S_VAL,
    S_SLASH
  } state_e;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic logic is_name_char(input logic [7:0] c);
    return !(is_ws(c) || c == CH_GT || c == CH_LT || c == CH_EQ || c == CH_QUOTE);
  endfunction

endpackage

// File: rtl/tag_stream_parser_if.sv
// Character-in / event-out bundle for tag_stream_parser; slave is the parser side.
interface tag_stream_parser_if #(
  parameter int CHAR_W   = 8,
  parameter int NAME_LEN = 8,
  parameter int VAL_LEN  = 16
);
  localparam int NLW = $clog2(NAME_LEN + 1);
  localparam int VLW = $clog2(VAL_LEN + 1);

  logic [CHAR_W-1:0]          in_char;
  logic                       in_valid;
  logic                       in_ready;
  logic                       evt_valid;
  logic                       evt_ready;
  logic [2:0]                 evt_type;
  logic [NAME_LEN*CHAR_W-1:0] evt_name;
  logic [NLW-1:0]             evt_name_len;
  logic [VAL_LEN*CHAR_W-1:0]  evt_value;
  logic [VLW-1:0]             evt_value_len;
  logic                       evt_trunc;

  modport master (
    output in_char, in_valid, evt_ready,
    input  in_ready, evt_valid, evt_type, evt_name, evt_name_len,
           evt_value, evt_value_len, evt_trunc
  );

  modport slave (
    input  in_char, in_valid, evt_ready,
    output in_ready, evt_valid, evt_type, evt_name, evt_name_len,
           evt_value, evt_value_len, evt_trunc
  );
endinterface

// File: rtl/char_accum.sv
// Append-only character buffer with stored length and a sticky overflow flag.
module char_accum #(
  parameter  int LEN    = 8,
  parameter  int CHAR_W = 8,
  localparam int LW     = $clog2(LEN + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  append,
  input  logic [CHAR_W-1:0]     ch,
  output logic [LEN*CHAR_W-1:0] data_o,
  output logic [LW-1:0]         len_o,
  output logic                  trunc_o
);
  localparam logic [LW-1:0] FULL = LW'(LEN);

  logic [LEN*CHAR_W-1:0] data_q, data_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  trunc_q, trunc_d;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    data_d  = data_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    if (clear) begin
      data_d  = '0;
      len_d   = '0;
      trunc_d = 1'b0;
    end else if (append) begin
      if (len_q == FULL) begin
        trunc_d = 1'b1;
      end else begin
        data_d[len_q*CHAR_W +: CHAR_W] = ch;
        len_d = len_q + LW'(1);
      end
    end
  end

  // NOTE: the buffer is a handful of flops, not a RAM, so it is reset so unused bytes read as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      data_q  <= data_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
    end
  end

  assign data_o  = data_q;
  assign len_o   = len_q;
  assign trunc_o = trunc_q;
endmodule

// File: rtl/tag_stream_parser.sv
// Streaming XML/HTML tag tokenizer emitting START/END/ATTR/ERROR events with backpressure.
// Define SELF_CLOSING_EN to recognise "/>" and emit SELF_CLOSE; otherwise '/' after a name acts as whitespace.
module tag_stream_parser
  import xml_pkg::*;
#(
  parameter int CHAR_W   = 8,
  parameter int NAME_LEN = 8,
  parameter int VAL_LEN  = 16
) (
  input logic               clock,
  input logic               reset,
  tag_stream_parser_if.slave bus
);
  localparam int NW  = NAME_LEN * CHAR_W;
  localparam int VW  = VAL_LEN * CHAR_W;
  localparam int NLW = $clog2(NAME_LEN + 1);
  localparam int VLW = $clog2(VAL_LEN + 1);

  typedef struct packed {
    logic [NW-1:0]  data;
    logic [NLW-1:0] len;
    logic           trunc;
  } name_t;

  typedef struct packed {
    logic [2:0]     etype;
    name_t          name;
    logic [VW-1:0]  value;
    logic [VLW-1:0] value_len;
    logic           vtrunc;
  } evt_t;

  state_e state_q, state_d;
  logic   is_end_q, is_end_d;
  logic   evt_valid_q, evt_valid_d;
  evt_t   evt_q, evt_d;

  logic           name_clr, name_app, val_clr, val_app;
  logic           emit, err;
  logic [2:0]     emit_type, tag_type;
  name_t          name_cur;
  logic [VW-1:0]  val_data;
  logic [VLW-1:0] val_len;
  logic           val_trunc;
  logic [7:0]     c;
  logic           accept;

`ifdef SELF_CLOSING_EN
  name_t tag_q, tag_d;
  logic  from_tag;
`endif

  assign c           = bus.in_char[7:0];
  assign bus.in_ready = !evt_valid_q || bus.evt_ready;
  assign accept      = bus.in_valid && bus.in_ready;
  assign tag_type    = is_end_q ? EVT_END : EVT_START;

  char_accum #(.LEN(NAME_LEN), .CHAR_W(CHAR_W)) u_name_acc (
    .clock(clock), .reset(reset), .clear(name_clr), .append(name_app), .ch(bus.in_char),
    .data_o(name_cur.data), .len_o(name_cur.len), .trunc_o(name_cur.trunc)
  );

  char_accum #(.LEN(VAL_LEN), .CHAR_W(CHAR_W)) u_val_acc (
    .clock(clock), .reset(reset), .clear(val_clr), .append(val_app), .ch(bus.in_char),
    .data_o(val_data), .len_o(val_len), .trunc_o(val_trunc)
  );

  always_comb begin
    state_d   = state_q;
    is_end_d  = is_end_q;
    name_clr  = 1'b0;
    name_app  = 1'b0;
    val_clr   = 1'b0;
    val_app   = 1'b0;
    emit      = 1'b0;
    err       = 1'b0;
    emit_type = EVT_START;
`ifdef SELF_CLOSING_EN
    tag_d     = tag_q;
    from_tag  = 1'b0;
`endif
    if (accept) begin
      unique case (state_q)
        S_CONTENT: if (c == CH_LT) begin state_d = S_OPEN; is_end_d = 1'b0; end
        S_OPEN: begin
          if (c == CH_SLASH) begin
            if (is_end_q) err = 1'b1;
            else          is_end_d = 1'b1;
          end else if (is_name_char(c)) begin
            name_app = 1'b1;
            state_d  = S_NAME;
          end else err = 1'b1;
        end
        S_NAME: begin
          // '/' is itself a name char, so it must be tested first
          if (c == CH_SLASH) begin
            emit = 1'b1;
`ifdef SELF_CLOSING_EN
            state_d = S_SLASH;
`else
            emit_type = tag_type;
            state_d   = S_ATTR_WS;
`endif
          end else if (is_name_char(c)) name_app = 1'b1;
          else if (is_ws(c))   begin emit = 1'b1; emit_type = tag_type; state_d = S_ATTR_WS; end
          else if (c == CH_GT) begin emit = 1'b1; emit_type = tag_type; state_d = S_CONTENT; end
          else err = 1'b1;
        end
        S_ATTR_WS: begin
          if (c == CH_SLASH) begin
`ifdef SELF_CLOSING_EN
            state_d = S_SLASH;
`endif
          end else if (is_ws(c)) state_d = S_ATTR_WS;
          else if (c == CH_GT) state_d = S_CONTENT;
          else if (is_name_char(c)) begin name_app = 1'b1; state_d = S_KEY; end
          else err = 1'b1;
        end
        S_KEY: begin
          if (is_name_char(c)) name_app = 1'b1;
          else if (c == CH_EQ) state_d = S_EQ;
          else if (c == CH_GT) begin emit = 1'b1; emit_type = EVT_ATTR; state_d = S_CONTENT; end
          else if (is_ws(c))   begin emit = 1'b1; emit_type = EVT_ATTR; state_d = S_ATTR_WS; end
          else err = 1'b1;
        end
        S_EQ: begin
          if (c == CH_QUOTE) state_d = S_VAL;
          else               err = 1'b1;
        end
        S_VAL: begin
          if (c == CH_QUOTE) begin emit = 1'b1; emit_type = EVT_ATTR; state_d = S_ATTR_WS; end
          else               val_app = 1'b1;
        end
`ifdef SELF_CLOSING_EN
        S_SLASH: begin
          if (c == CH_GT) begin
            emit = 1'b1; emit_type = EVT_SELF_CLOSE; from_tag = 1'b1; state_d = S_CONTENT;
          end else err = 1'b1;
        end
`endif
        default: state_d = S_CONTENT;
      endcase
    end

    if (err) begin
      emit      = 1'b1;
      emit_type = EVT_ERROR;
      state_d   = S_CONTENT;
    end

    evt_valid_d = evt_valid_q && !bus.evt_ready;
    evt_d       = evt_q;
    if (emit) begin
      evt_valid_d     = 1'b1;
      evt_d.etype     = emit_type;
      evt_d.name      = name_cur;
      evt_d.value     = (emit_type == EVT_ATTR) ? val_data : '0;
      evt_d.value_len = (emit_type == EVT_ATTR) ? val_len : '0;
      evt_d.vtrunc    = (emit_type == EVT_ATTR) && val_trunc;
      name_clr        = 1'b1;
      val_clr         = 1'b1;
`ifdef SELF_CLOSING_EN
      if (from_tag) evt_d.name = tag_q;
      if (emit_type == EVT_START) tag_d = name_cur;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_CONTENT;
      is_end_q    <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
`ifdef SELF_CLOSING_EN
      tag_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_end_q    <= is_end_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
`ifdef SELF_CLOSING_EN
      tag_q       <= tag_d;
`endif
    end
  end

  assign bus.evt_valid     = evt_valid_q;
  assign bus.evt_type      = evt_q.etype;
  assign bus.evt_name      = evt_q.name.data;
  assign bus.evt_name_len  = evt_q.name.len;
  assign bus.evt_value     = evt_q.value;
  assign bus.evt_value_len = evt_q.value_len;
  assign bus.evt_trunc     = evt_q.name.trunc || evt_q.vtrunc;
endmodule

// File: tb/tb_tag_stream_parser.sv
// Scoreboard bench for tag_stream_parser: directed documents, hand-written expected events.
module tb_tag_stream_parser;
  localparam int CW  = 8;
  localparam int NL  = 4;
  localparam int VL  = 16;
  localparam int NW  = NL * CW;
  localparam int VW  = VL * CW;
  localparam int NLW = $clog2(NL + 1);
  localparam int VLW = $clog2(VL + 1);

  localparam logic [2:0] T_START = 3'd0, T_END = 3'd1, T_ATTR = 3'd2, T_SC = 3'd3, T_ERR = 3'd7;

  typedef struct packed {
    logic [2:0]     t;
    logic [NW-1:0]  n;
    logic [NLW-1:0] nl;
    logic [VW-1:0]  v;
    logic [VLW-1:0] vl;
    logic           tr;
  } ev_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  ev_t   exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    stall_left = 0;
  string cur_test = "reset";
  string dq;

  tag_stream_parser_if #(.CHAR_W(CW), .NAME_LEN(NL), .VAL_LEN(VL)) bus ();

  tag_stream_parser #(.CHAR_W(CW), .NAME_LEN(NL), .VAL_LEN(VL)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] t, input string n, input string v, input logic tr);
    ev_t e;
    e = '0;
    e.t = t;
    for (int i = 0; i < n.len(); i++) e.n[i*CW +: CW] = n[i];
    for (int i = 0; i < v.len(); i++) e.v[i*CW +: CW] = v[i];
    e.nl = NLW'(n.len());
    e.vl = VLW'(v.len());
    e.tr = tr;
    return e;
  endfunction

  function automatic ev_t sample();
    return {bus.evt_type, bus.evt_name, bus.evt_name_len,
            bus.evt_value, bus.evt_value_len, bus.evt_trunc};
  endfunction

  // Called on a negedge; returns on the negedge after the char is taken.
  task automatic send_char(input byte ch);
    int n;
    n = 0;
    bus.in_char  = ch;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check({cur_test, ":in_ready_timeout"}, 256'(bus.in_ready), 256'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic run(input string name, input string s);
    int n;
    cur_test = name;
    send_str(s);
    n = 0;
    while ((exp_q.size() != 0 || bus.evt_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({name, ":drain_timeout"}, 256'(exp_q.size()), 256'(0));
    repeat (3) @(negedge clk);
  endtask

  // Monitor: drives evt_ready, compares every presented event with the queue head.
  initial begin
    ev_t cur;
    bus.evt_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.evt_valid && stall_left > 0) begin
        bus.evt_ready = 1'b0;
        stall_left--;
      end else begin
        bus.evt_ready = 1'b1;
      end
      #2;
      if (bus.evt_valid) begin
        cur = sample();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s:unexpected_event: got %h expected none", cur_test, cur);
        end else if (!bus.evt_ready) begin
          check({cur_test, ":stall_in_ready"}, 256'(bus.in_ready), 256'(0));
          check({cur_test, ":stall_hold"}, 256'(cur), 256'(exp_q[0]));
        end else begin
          check({cur_test, ":event"}, 256'(cur), 256'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dq = " ";
    dq.putc(0, 8'h22);
    bus.in_char  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:evt_valid", 256'(bus.evt_valid), 256'(0));
    check("reset:in_ready", 256'(bus.in_ready), 256'(1));
    check("reset:evt_fields", 256'(sample()), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    exp_q.push_back(mk(T_START, "div", "", 1'b0));
    run("div", "<div>");

    exp_q.push_back(mk(T_END, "p", "", 1'b0));
    run("end_p", "</p>");

    exp_q.push_back(mk(T_START, "q", "", 1'b0));
    run("content", "hi x<q>");

    exp_q.push_back(mk(T_START, "a", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "href", "x>y", 1'b0));
    run("href", {"<a href=", dq, "x>y", dq, ">"});

    stall_left = 5;
    exp_q.push_back(mk(T_START, "body", "", 1'b0));
    exp_q.push_back(mk(T_END, "body", "", 1'b0));
    run("stall", "<body></body>");

    exp_q.push_back(mk(T_START, "abcd", "", 1'b1));
    run("name_trunc", "<abcdefg>");

    exp_q.push_back(mk(T_START, "x", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "k", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "v", "", 1'b0));
    run("empty_vals", {"<x k v=", dq, dq, ">"});

    exp_q.push_back(mk(T_START, "v", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "s", "0123456789ABCDEF", 1'b1));
    run("val_trunc", {"<v s=", dq, "0123456789ABCDEFG", dq, ">"});

    exp_q.push_back(mk(T_END, "p", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "x", "1", 1'b0));
    run("end_attr", {"</p x=", dq, "1", dq, ">"});

    exp_q.push_back(mk(T_START, "img", "", 1'b0));
`ifdef SELF_CLOSING_EN
    exp_q.push_back(mk(T_SC, "img", "", 1'b0));
`endif
    run("img", "<img/>");

    exp_q.push_back(mk(T_START, "img", "", 1'b0));
    exp_q.push_back(mk(T_ATTR, "a", "1", 1'b0));
`ifdef SELF_CLOSING_EN
    exp_q.push_back(mk(T_SC, "img", "", 1'b0));
`endif
    run("img_attr", {"<img a=", dq, "1", dq, "/>"});

    exp_q.push_back(mk(T_ERR, "", "", 1'b0));
    run("err_eq", "<=x>");

    exp_q.push_back(mk(T_ERR, "", "", 1'b0));
    run("err_slash", "<//>");

    exp_q.push_back(mk(T_ERR, "ab", "", 1'b0));
    run("err_lt", "<ab<c>");

    cur_test = "mid_reset";
    send_str("<di");
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_reset:evt_valid", 256'(bus.evt_valid), 256'(0));
    check("mid_reset:in_ready", 256'(bus.in_ready), 256'(1));
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(mk(T_START, "p", "", 1'b0));
    run("after_reset", "<p>");

    check("final:queue_empty", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
